// File: rtl/alarm_controller.sv
// Alarm setpoint store, HH:MM match and ring/snooze FSM.
// All timing comes from the 1 Hz Tick strobe.
module alarm_controller #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int TW         = 9
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic [3:0] HR_T,
  input  logic [3:0] HR_U,
  input  logic [3:0] MIN_T,
  input  logic [3:0] MIN_U,
  input  logic [3:0] AL_IN_HT,
  input  logic [3:0] AL_IN_HU,
  input  logic [3:0] AL_IN_MT,
  input  logic [3:0] AL_IN_MU,
  input  logic       LD_AL,
  input  logic       Alarm_En,
  input  logic       Snooze,
  input  logic       Off,
  output logic [3:0] AL_HT,
  output logic [3:0] AL_HU,
  output logic [3:0] AL_MT,
  output logic [3:0] AL_MU,
  output logic       Ringing,
  output logic       Snoozing,
  output logic       Buzz
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [TW-1:0] T_RING = TW'(RING_SEC);
  localparam logic [TW-1:0] T_SNZ  = TW'(SNOOZE_SEC);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic          buzz_q, buzz_d;
  logic          match, match_q, rise;
  logic          quit;

  assign match = (HR_T == AL_HT) & (HR_U == AL_HU) &
                 (MIN_T == AL_MT) & (MIN_U == AL_MU);
  assign rise  = match & ~match_q;
  assign quit  = Off | ~Alarm_En;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state   <= IDLE;
      timer   <= '0;
      buzz_q  <= 1'b0;
      match_q <= 1'b1;
      AL_HT   <= '0;
      AL_HU   <= '0;
      AL_MT   <= '0;
      AL_MU   <= '0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      buzz_q  <= buzz_d;
      match_q <= match;
      if (LD_AL) begin
        AL_HT <= AL_IN_HT;
        AL_HU <= AL_IN_HU;
        AL_MT <= AL_IN_MT;
        AL_MU <= AL_IN_MU;
      end
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    buzz_d  = buzz_q;
    unique case (state)
      IDLE: begin
        timer_d = '0;
        buzz_d  = 1'b0;
        if (Alarm_En & rise) begin
          state_d = RINGING;
          timer_d = T_RING;
          buzz_d  = 1'b1;
        end
      end
      RINGING: begin
        if (quit) begin
          state_d = IDLE;
          timer_d = '0;
          buzz_d  = 1'b0;
        end else if (Snooze) begin
          state_d = SNOOZE;
          timer_d = T_SNZ;
          buzz_d  = 1'b0;
        end else if (Tick) begin
          if (timer == T_ONE) begin
            state_d = IDLE;
            timer_d = '0;
            buzz_d  = 1'b0;
          end else begin
            timer_d = timer - T_ONE;
            buzz_d  = ~buzz_q;
          end
        end
      end
      SNOOZE: begin
        buzz_d = 1'b0;
        if (quit) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (Tick) begin
          if (timer == T_ONE) begin
            state_d = RINGING;
            timer_d = T_RING;
            buzz_d  = 1'b1;
          end else begin
            timer_d = timer - T_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        buzz_d  = 1'b0;
      end
    endcase
  end

  assign Ringing  = (state == RINGING);
  assign Snoozing = (state == SNOOZE);
  assign Buzz     = buzz_q;

endmodule
